seq_mult_param: RTL and testbench

Parametrised sequential shift-add multiplier. It is the successor to the fixed 4×4 combinational array multiplier. It multiplies two WIDTH-bit operands in signed or unsigned mode over WIDTH clock cycles and uses valid/ready handshakes on both input and output. It sits behind the Tiny Tapeout top-level wrapper, where the wrapper maps operands from `ui_in`/`uio_in` and drives the product onto `uo_out`/`uio_out`.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_sign_conv.sv | 12 +
 rtl/seq_mult_param.sv | 124 ++++++++++++
 tb/tb_seq_mult_param.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Iteration counter width: ceil(log2(n)), at least one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mult_sign_conv.sv
// Conditional two's-complement negate: y = neg ? -x : x.
module mult_sign_conv #(
    parameter int W = 4
) (
    input  logic [W-1:0] x_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? (~x_i + W'(1)) : x_i;

endmodule

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, signed/unsigned, WIDTH iterations.
module seq_mult_param
    import mult_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mult_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    product_q, product_d;

    logic             signed_eff;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    acc_step;
    logic [PW-1:0]    result;

    assign signed_eff = SIGNED_EN & signed_mode;

    mult_sign_conv #(.W(WIDTH)) u_mag_a (
        .x_i   (a),
        .neg_i (signed_eff & a[WIDTH-1]),
        .y_o   (mag_a)
    );

    mult_sign_conv #(.W(WIDTH)) u_mag_b (
        .x_i   (b),
        .neg_i (signed_eff & b[WIDTH-1]),
        .y_o   (mag_b)
    );

    // Add into the upper half, then shift the whole accumulator right.
    assign sum = {1'b0, acc_q[PW-1:WIDTH]}
               + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step = {sum, acc_q[WIDTH-1:1]};

    mult_sign_conv #(.W(PW)) u_res (
        .x_i   (acc_step),
        .neg_i (neg_q),
        .y_o   (result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = RUN;
                    mcand_d  = mag_a;
                    mplier_d = mag_b;
                    neg_d    = signed_eff & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    product_d = result;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed checks for seq_mult_param at WIDTH=4 and WIDTH=8 unsigned-only.
module tb_seq_mult_param;

    logic clk;
    logic rst;

    logic       iv4, ir4, sm4, ov4, or4, busy4;
    logic [3:0] a4, b4;
    logic [7:0] p4;

    logic        iv8, ir8, sm8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int checks;
    int errors;

    seq_mult_param #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (iv4),
        .in_ready    (ir4),
        .a           (a4),
        .b           (b4),
        .signed_mode (sm4),
        .out_valid   (ov4),
        .out_ready   (or4),
        .product     (p4),
        .busy        (busy4)
    );

    seq_mult_param #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (iv8),
        .in_ready    (ir8),
        .a           (a8),
        .b           (b8),
        .signed_mode (sm8),
        .out_valid   (ov8),
        .out_ready   (or8),
        .product     (p8),
        .busy        (busy8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       input logic sm, input logic [7:0] exp,
                       input string tag, input bit bp);
        @(negedge clk);
        a4 = a; b4 = b; sm4 = sm; iv4 = 1'b1; or4 = !bp;
        check({tag, ".rdy"}, 32'(ir4), 32'd1);
        @(posedge clk); #1;
        iv4 = 1'b0;
        check({tag, ".busy"}, 32'(busy4), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".early"}, 32'(ov4), 32'd0);
        @(posedge clk); #1;
        check({tag, ".valid"}, 32'(ov4), 32'd1);
        check({tag, ".prod"}, 32'(p4), 32'(exp));
        if (bp) begin
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                check({tag, ".hold"}, 32'(p4), 32'(exp));
                check({tag, ".hvld"}, 32'(ov4), 32'd1);
                check({tag, ".hrdy"}, 32'(ir4), 32'd0);
            end
            or4 = 1'b1;
            @(posedge clk); #1;
            or4 = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
        check({tag, ".idle"}, 32'(ir4), 32'd1);
        check({tag, ".ovlo"}, 32'(ov4), 32'd0);
        check({tag, ".keep"}, 32'(p4), 32'(exp));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        iv4 = 0; sm4 = 0; or4 = 1; a4 = '0; b4 = '0;
        iv8 = 0; sm8 = 0; or8 = 1; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst.rdy", 32'(ir4), 32'd1);
        check("rst.ov", 32'(ov4), 32'd0);
        check("rst.busy", 32'(busy4), 32'd0);
        check("rst.prod", 32'(p4), 32'd0);
        check("rst8.rdy", 32'(ir8), 32'd1);
        check("rst8.prod", 32'(p8), 32'd0);

        op4(4'd13, 4'd11, 1'b0, 8'h8F, "u13x11", 1'b0);
        op4(4'hD, 4'd5, 1'b1, 8'hF1, "sm3x5", 1'b0);
        op4(4'h8, 4'h8, 1'b1, 8'h40, "sm8xm8", 1'b0);
        op4(4'd7, 4'hF, 1'b1, 8'hF9, "s7xm1", 1'b0);
        op4(4'd15, 4'd15, 1'b0, 8'hE1, "u15x15", 1'b0);
        op4(4'd0, 4'd9, 1'b0, 8'h00, "u0x9", 1'b0);
        op4(4'd6, 4'd7, 1'b0, 8'h2A, "bp6x7", 1'b1);

        // Abort mid-run: reset lands on the second iteration edge.
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd3; sm4 = 1'b0; iv4 = 1'b1; or4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.ov", 32'(ov4), 32'd0);
        check("abort.prod", 32'(p4), 32'd0);
        check("abort.busy", 32'(busy4), 32'd0);
        check("abort.rdy", 32'(ir4), 32'd1);
        op4(4'd3, 4'hE, 1'b1, 8'hFA, "post3xm2", 1'b0);

        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; sm8 = 1'b1; iv8 = 1'b1; or8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("w8.early", 32'(ov8), 32'd0);
        @(posedge clk); #1;
        check("w8.valid", 32'(ov8), 32'd1);
        check("w8.prod", 32'(p8), 32'hFE01);
        @(posedge clk); #1;
        check("w8.idle", 32'(ir8), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
